mandelbrot_point_generator: RTL and testbench

Computes the escape-time iteration count of one Mandelbrot point for the rendering engine. On a start pulse it maps pixel coordinates (x, y) to c = (re_start + x·re_scale) + i(im_start + y·im_scale). It then iterates z ← z² + c from z = 0, performing one iteration per clock. It includes a signed fixed-point multiplier sub-function equivalent to signedFixedPointMult. The engine instantiates one unit per point in a set and waits for all done flags before collecting counts.

---
 rtl/mandelbrot_point_generator_if.sv | 27 ++
 rtl/mandelbrot_point_generator.sv | 156 +++++++++++++++
 tb/tb_mandelbrot_point_generator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mandelbrot_point_generator_if.sv
// Request/result bundle between the rendering engine and one point generator.
// The engine owns start and the c-plane mapping; the generator owns done/iteration.
interface mandelbrot_point_generator_if #(
    parameter int W       = 33,
    parameter int COORD_W = 12,
    parameter int ITER_W  = 32
);
    logic                      start;
    logic signed [W-1:0]       re_scale;
    logic signed [W-1:0]       im_scale;
    logic signed [W-1:0]       re_start;
    logic signed [W-1:0]       im_start;
    logic        [COORD_W-1:0] x;
    logic        [COORD_W-1:0] y;
    logic                      done;
    logic        [ITER_W-1:0]  iteration;

    modport master (
        output start, re_scale, im_scale, re_start, im_start, x, y,
        input  done, iteration
    );

    modport slave (
        input  start, re_scale, im_scale, re_start, im_start, x, y,
        output done, iteration
    );
endinterface

// File: rtl/mandelbrot_point_generator.sv
// Escape-time iteration count for one Mandelbrot point, one z <- z^2 + c step per clock.
// Define MPG_SATURATE_EN to clamp out-of-range results; otherwise results wrap.
module mandelbrot_point_generator #(
    parameter int INT_W    = 4,
    parameter int FRAC_W   = 29,
    parameter int COORD_W  = 12,
    parameter int ITER_W   = 32,
    parameter int MAX_ITER = 255
) (
    input  logic CLK,
    input  logic reset,
    mandelbrot_point_generator_if.slave bus
);
    localparam int W  = INT_W + FRAC_W;
    localparam int WX = 2 * W + 1;

    localparam logic signed [WX-1:0] SAT_MAX = {{(WX-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [WX-1:0] SAT_MIN = {{(WX-W+1){1'b1}}, {(W-1){1'b0}}};
    // 4.0 expressed in the scale of a full-precision square (2*FRAC_W fraction bits)
    localparam logic [WX-1:0] FOUR_SQ = WX'(1) << (2 * FRAC_W + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        ITER  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic        [COORD_W-1:0] x_q, y_q;
    logic signed [W-1:0]       c_re, c_im;
    logic signed [W-1:0]       zr, zi;
    logic        [ITER_W-1:0]  count;
    logic                      done_q;
    logic        [ITER_W-1:0]  iteration_q;

    function automatic logic signed [WX-1:0] ext(input logic signed [W-1:0] a);
        return {{(WX-W){a[W-1]}}, a};
    endfunction

    function automatic logic signed [W-1:0] reduce(input logic signed [WX-1:0] v);
`ifdef MPG_SATURATE_EN
        if (v > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return W'(v);
`else
        return W'(v);
`endif
    endfunction

    // Full product, optionally doubled before the floor shift so 2*zr*zi keeps its LSB.
    function automatic logic signed [W-1:0] fmul(input logic signed [W-1:0] a,
                                                 input logic signed [W-1:0] b,
                                                 input logic               dbl);
        logic signed [2*W-1:0] p;
        logic signed [WX-1:0]  pe;
        p  = a * b;
        pe = {p[2*W-1], p};
        if (dbl)
            pe = pe <<< 1;
        return reduce(pe >>> FRAC_W);
    endfunction

    function automatic logic signed [W-1:0] map_coord(input logic [COORD_W-1:0] pix,
                                                      input logic signed [W-1:0]  scale,
                                                      input logic signed [W-1:0]  origin);
        logic signed [WX-1:0] prod;
        logic signed [W-1:0]  prod_r;
        prod   = $signed({{(WX-COORD_W){1'b0}}, pix}) * ext(scale);
        prod_r = reduce(prod);
        return reduce(ext(prod_r) + ext(origin));
    endfunction

    logic signed [2*W-1:0] sq_r, sq_i;
    logic        [WX-1:0]  mag;
    logic                  escape;
    logic                  at_cap;
    logic signed [W-1:0]   zr_sq, zi_sq, zr_diff;
    logic signed [W-1:0]   zr_next, zi_next;
    logic signed [W-1:0]   c_re_next, c_im_next;

    always_comb begin
        state_d   = state_q;
        sq_r      = zr * zr;
        sq_i      = zi * zi;
        // Both squares are non-negative, so their sign bits are zero and the sum cannot overflow WX bits.
        mag       = {1'b0, sq_r} + {1'b0, sq_i};
        escape    = mag > FOUR_SQ;
        at_cap    = count == ITER_W'(MAX_ITER);
        zr_sq     = fmul(zr, zr, 1'b0);
        zi_sq     = fmul(zi, zi, 1'b0);
        zr_diff   = reduce(ext(zr_sq) - ext(zi_sq));
        zr_next   = reduce(ext(zr_diff) + ext(c_re));
        zi_next   = reduce(ext(fmul(zr, zi, 1'b1)) + ext(c_im));
        c_re_next = map_coord(x_q, bus.re_scale, bus.re_start);
        c_im_next = map_coord(y_q, bus.im_scale, bus.im_start);

        case (state_q)
            IDLE:    if (bus.start) state_d = SETUP;
            SETUP:   state_d = ITER;
            ITER:    if (escape || at_cap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            c_re        <= '0;
            c_im        <= '0;
            zr          <= '0;
            zi          <= '0;
            count       <= '0;
            done_q      <= 1'b1;
            iteration_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        x_q    <= bus.x;
                        y_q    <= bus.y;
                        done_q <= 1'b0;
                    end
                end
                SETUP: begin
                    c_re  <= c_re_next;
                    c_im  <= c_im_next;
                    zr    <= '0;
                    zi    <= '0;
                    count <= '0;
                end
                ITER: begin
                    if (escape || at_cap) begin
                        iteration_q <= count;
                        done_q      <= 1'b1;
                    end else begin
                        zr    <= zr_next;
                        zi    <= zi_next;
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.iteration = iteration_q;

endmodule

// File: tb/tb_mandelbrot_point_generator.sv
// Directed escape-time checks: reset, outside point, origin, -2 boundary, scaled c = 1, busy start, mid-run reset.
module tb_mandelbrot_point_generator;
    logic CLK;
    logic reset;
    int   total;
    int   bad;
    int   edge_n;

    mandelbrot_point_generator_if bus ();

    mandelbrot_point_generator dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulse start across one rising edge (edge 0) and check done fell on it.
    task automatic pulse_start(input string tag);
        bus.start = 1'b1;
        @(posedge CLK);
        #1;
        check({tag, "_done_low_e0"}, 64'(bus.done), 64'd0);
        bus.start = 1'b0;
    endtask

    // Returns the edge index (relative to edge 0) on which done rose, or -1 on timeout.
    task automatic wait_done(input int from, output int edge_out);
        edge_out = -1;
        for (int e = from + 1; e <= 400; e++) begin
            @(posedge CLK);
            #1;
            if (bus.done) begin
                edge_out = e;
                break;
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start    = 1'b0;
        bus.re_scale = '0;
        bus.im_scale = '0;
        bus.re_start = '0;
        bus.im_start = '0;
        bus.x        = '0;
        bus.y        = '0;

        #12;
        check("reset_done", 64'(bus.done), 64'd1);
        check("reset_iter", 64'(bus.iteration), 64'd0);
        #10;
        reset = 1'b0;
        @(posedge CLK);
        #1;

        // c = -2.5: escapes after the first step
        bus.re_start = -33'sd1342177280;
        pulse_start("outside");
        wait_done(0, edge_n);
        check("outside_edge", 64'(edge_n), 64'd3);
        check("outside_iter", 64'(bus.iteration), 64'd1);

        // c = 0 never escapes
        bus.re_start = '0;
        pulse_start("origin");
        wait_done(0, edge_n);
        check("origin_edge", 64'(edge_n), 64'd257);
        check("origin_iter", 64'(bus.iteration), 64'd255);

        // c = -2: z pins at 2, |z|^2 == 4.0 exactly, not an escape
        bus.re_start = -33'sd1073741824;
        pulse_start("boundary");
        wait_done(0, edge_n);
        check("boundary_edge", 64'(edge_n), 64'd257);
        check("boundary_iter", 64'(bus.iteration), 64'd255);

        // c = -2 + 12*0.25 = 1: z 0,1,2,5
        bus.re_scale = 33'sd134217728;
        bus.x        = 12'd12;
        pulse_start("scale");
        check("scale_iter_held", 64'(bus.iteration), 64'd255);
        bus.x = 12'd0;
        wait_done(0, edge_n);
        check("scale_edge", 64'(edge_n), 64'd5);
        check("scale_iter", 64'(bus.iteration), 64'd3);

        // c = 0 with a second start carrying x = 12 mid-run: must be ignored
        bus.re_start = '0;
        bus.x        = 12'd0;
        pulse_start("busy");
        repeat (10) @(posedge CLK);
        #1;
        bus.start = 1'b1;
        bus.x     = 12'd12;
        @(posedge CLK);
        #1;
        check("busy_done_low", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        wait_done(11, edge_n);
        check("busy_edge", 64'(edge_n), 64'd257);
        check("busy_iter", 64'(bus.iteration), 64'd255);
        repeat (5) @(posedge CLK);
        #1;
        check("busy_done_stays", 64'(bus.done), 64'd1);
        check("busy_iter_stays", 64'(bus.iteration), 64'd255);

        // Reset mid-ITER aborts and clears immediately; the next run still completes
        bus.x = 12'd0;
        pulse_start("rst_run");
        repeat (20) @(posedge CLK);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_done", 64'(bus.done), 64'd1);
        check("midrst_iter", 64'(bus.iteration), 64'd0);
        @(posedge CLK);
        #4;
        reset = 1'b0;
        @(posedge CLK);
        #1;
        check("postrst_iter", 64'(bus.iteration), 64'd0);
        pulse_start("after_rst");
        wait_done(0, edge_n);
        check("after_rst_edge", 64'(edge_n), 64'd257);
        check("after_rst_iter", 64'(bus.iteration), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
